// File: rtl/mult_div_unit_if.sv
// Bus between the execute stage and the multiply/divide unit.
// The master side launches operations and issues MTHI/MTLO writes.
// The slave side returns busy/done and the architectural HI/LO values.
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] srcA;
  logic [WIDTH-1:0] srcB;
  logic             hiWrite;
  logic             loWrite;
  logic [WIDTH-1:0] wrData;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, srcA, srcB, hiWrite, loWrite, wrData,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, srcA, srcB, hiWrite, loWrite, wrData,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit that owns the HI/LO registers.
// Operands are reduced to unsigned magnitudes at launch.
// Multiply uses radix-2 shift-add and divide uses restoring shift-subtract.
// Both run one bit per cycle and share a single double-width accumulator.
// Signs are restored in a final cycle before HI/LO are written.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input logic            clk,
  input logic            rst,
  mult_div_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

  state_t               state, state_next;
  logic [CW-1:0]        count;
  logic                 is_div;
  logic                 sign_a, sign_b;
  logic [WIDTH-1:0]     opnd;
  logic [2*WIDTH-1:0]   acc;
  logic [WIDTH-1:0]     hi_q, lo_q;
  logic                 done_q;

  logic                 in_signed;
  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       rem_shift;
  logic                 rem_ge;
  logic [WIDTH-1:0]     rem_sub;
  logic [2*WIDTH-1:0]   acc_step;
  logic                 div_zero;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix, rem_fix;

  assign bus.busy = (state != IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

  // Operand magnitudes at launch; unsigned ops pass straight through
  always_comb begin
    in_signed = ~bus.op[0];
    mag_a     = (in_signed && bus.srcA[WIDTH-1]) ? -bus.srcA : bus.srcA;
    mag_b     = (in_signed && bus.srcB[WIDTH-1]) ? -bus.srcB : bus.srcB;
  end

  // One multiply or divide iteration on the shared accumulator
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    rem_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    rem_ge    = (rem_shift >= {1'b0, opnd});
    rem_sub   = rem_shift[WIDTH-1:0] - opnd;
    acc_step  = {mul_sum, acc[WIDTH-1:1]};
    if (is_div) begin
      if (rem_ge) acc_step = {rem_sub, acc[WIDTH-2:0], 1'b1};
      else        acc_step = {rem_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end
  end

  // Sign restoration; a zero divisor keeps the raw restoring result
  always_comb begin
    div_zero = (opnd == '0);
    prod_fix = (sign_a ^ sign_b) ? -acc : acc;
    quo_fix  = ((sign_a ^ sign_b) && !div_zero) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = (sign_a && !div_zero) ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  // Next-state logic for the IDLE -> CALC -> FINISH sequence
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = CALC;
      CALC:    if (count == CW'(WIDTH - 1)) state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Datapath: launch latching, per-cycle iteration, result and MTHI/MTLO writes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= '0;
      is_div <= 1'b0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      opnd   <= '0;
      acc    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.hiWrite) hi_q <= bus.wrData;
          if (bus.loWrite) lo_q <= bus.wrData;
          if (bus.start) begin
            is_div <= bus.op[1];
            sign_a <= in_signed & bus.srcA[WIDTH-1];
            sign_b <= in_signed & bus.srcB[WIDTH-1];
            count  <= '0;
            if (bus.op[1]) begin
              opnd <= mag_b;
              acc  <= {{WIDTH{1'b0}}, mag_a};
            end else begin
              opnd <= mag_a;
              acc  <= {{WIDTH{1'b0}}, mag_b};
            end
          end
        end
        CALC: begin
          acc   <= acc_step;
          count <= count + CW'(1);
        end
        FINISH: begin
          done_q <= 1'b1;
          if (is_div) begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end else begin
            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end
endmodule
